// File: rtl/muldiv_pkg.sv
// Shared CPU definitions: op codes, multiply/divide FSM states, ALU modes, flag bus.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package muldiv_pkg;

  localparam int unsigned DW = 8;
  localparam logic [2:0] LAST_ITER = 3'd7;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_PASS = 3'd7
  } alu_mode_e;

  // Same bit meaning as the ALU flag bus so the flag register needs no remap.
  typedef struct packed {
    logic c;
    logic z;
    logic n;
  } flags_t;

  // acc holds the 16-bit product (MUL) or the quotient in acc[7:0] (DIV).
  function automatic flags_t muldiv_flags(op_e op, logic [15:0] acc, logic [DW-1:0] divisor);
    flags_t f;
    if (op == OP_MUL) begin
      f.c = |acc[15:8];
      f.z = (acc == 16'h0000);
      f.n = acc[15];
    end else begin
      f.c = (divisor == '0);
      f.z = (acc[7:0] == 8'h00);
      f.n = acc[7];
    end
    return f;
  endfunction

endpackage

// File: rtl/muldiv.sv
// Iterative unsigned 8x8 multiply (shift-add) / 8/8 divide (restoring), one bit per cycle.
// Latency: start accepted at edge k -> busy after k+1..k+8, done pulse after k+9.
// Backpressure: none queued; start is ignored while an operation is in flight.
module muldiv
  import muldiv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op,
  input  logic [DW-1:0] dataA,
  input  logic [DW-1:0] dataB,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] outH,
  output logic [DW-1:0] outL,
  output logic          cout,
  output logic          zout,
  output logic          nout
);

  state_e        state_q;
  logic [2:0]    cnt_q;
  op_e           op_q;
  logic [DW-1:0] opa_q;
  logic [DW-1:0] opb_q;
  logic [15:0]   acc_q, acc_d;
  logic [8:0]    rem_q, rem_d;
  logic          busy_q, done_q;
  logic [DW-1:0] outh_q, outl_q;
  flags_t        flags_q, flags_d;

  logic [8:0]    mul_sum;
  logic [9:0]    div_shift;
  logic          div_ge;

  // One iteration of the shared datapath: add-and-shift-right for MUL,
  // shift-left-and-trial-subtract for DIV (quotient bits enter acc[0]).
  always_comb begin
    mul_sum   = {1'b0, acc_q[15:8]} + (acc_q[0] ? {1'b0, opa_q} : 9'd0);
    div_shift = {rem_q, acc_q[7]};
    div_ge    = (div_shift >= {2'b00, opb_q});
    acc_d     = acc_q;
    rem_d     = rem_q;
    if (op_q == OP_MUL) begin
      acc_d = {mul_sum, acc_q[7:1]};
    end else begin
      acc_d = {acc_q[15:8], acc_q[6:0], div_ge};
      rem_d = div_ge ? 9'(div_shift - {2'b00, opb_q}) : div_shift[8:0];
    end
    flags_d = muldiv_flags(op_q, acc_q, opb_q);
  end

  // Control FSM, operand latch, iteration and registered result/status outputs.
  // busy/done are registered from the state, so they trail it by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      op_q    <= OP_MUL;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      outh_q  <= '0;
      outl_q  <= '0;
      flags_q <= '0;
    end else begin
      busy_q <= (state_q == ST_RUN);
      done_q <= (state_q == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op_e'(op);
            opa_q   <= dataA;
            opb_q   <= dataB;
            // MUL consumes the multiplier from acc[0]; DIV shifts the dividend out of acc[7].
            acc_q   <= {8'h00, op ? dataA : dataB};
            rem_q   <= '0;
            cnt_q   <= 3'd0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == LAST_ITER) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          outh_q  <= (op_q == OP_MUL) ? acc_q[15:8] : rem_q[7:0];
          outl_q  <= acc_q[7:0];
          flags_q <= flags_d;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign outH = outh_q;
  assign outL = outl_q;
  assign cout = flags_q.c;
  assign zout = flags_q.z;
  assign nout = flags_q.n;

endmodule

// File: tb/tb_muldiv.sv
// Directed self-checking bench for muldiv.
// Latency: checks exact busy/done cycle positions relative to the accepting edge.
// Backpressure: checks that start is ignored while busy and honoured when held.
module tb_muldiv;

  logic       clk;
  logic       rst;
  logic       start;
  logic       op;
  logic [7:0] dataA;
  logic [7:0] dataB;
  logic       busy;
  logic       done;
  logic [7:0] outH;
  logic [7:0] outL;
  logic       cout;
  logic       zout;
  logic       nout;

  int n_cmp = 0;
  int n_err = 0;

  muldiv dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .dataA (dataA),
    .dataB (dataB),
    .busy  (busy),
    .done  (done),
    .outH  (outH),
    .outL  (outL),
    .cout  (cout),
    .zout  (zout),
    .nout  (nout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one operation. exp_res = {outH,outL}, exp_fl = {cout,zout,nout}.
  // With scramble set, inputs and start are randomised through RUN and the DONE cycle.
  task automatic run_op(input string tag, input logic o, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_res, input logic [2:0] exp_fl, input bit scramble);
    int busy_ok;
    logic [15:0] res_prev;
    res_prev = {outH, outL};
    op    = o;
    dataA = a;
    dataB = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy_after_accept"}, {14'd0, busy, done}, 16'd0);
    busy_ok = 0;
    for (int i = 1; i <= 8; i++) begin
      if (scramble) begin
        op    = 1'($urandom);
        dataA = 8'($urandom);
        dataB = 8'($urandom);
        start = 1'($urandom);
      end
      tick();
      if (busy === 1'b1 && done === 1'b0) busy_ok++;
      if (i == 4) chk({tag, " result_held_in_run"}, {outH, outL}, res_prev);
    end
    chk({tag, " busy_cycles"}, 16'(busy_ok), 16'd8);
    tick();
    start = 1'b0;
    chk({tag, " done_pulse"}, {14'd0, busy, done}, 16'd1);
    chk({tag, " result"}, {outH, outL}, exp_res);
    chk({tag, " flags"}, {13'd0, cout, zout, nout}, {13'd0, exp_fl});
    tick();
    chk({tag, " done_low"}, {14'd0, busy, done}, 16'd0);
    chk({tag, " result_hold"}, {outH, outL}, exp_res);
  endtask

  initial begin
    int dones;
    int first_t;
    int last_t;
    int stray;

    rst   = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    dataA = 8'h00;
    dataB = 8'h00;
    tick();
    tick();
    chk("reset_status", {14'd0, busy, done}, 16'd0);
    chk("reset_result", {outH, outL}, 16'h0000);
    chk("reset_flags", {13'd0, cout, zout, nout}, 16'd0);

    // Reset wins over start on the same edge.
    start = 1'b1;
    dataA = 8'h12;
    dataB = 8'h34;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    tick();
    chk("rst_priority_busy", {14'd0, busy, done}, 16'd0);

    run_op("mul_0f_11", 1'b0, 8'h0F, 8'h11, 16'h00FF, 3'b000, 1'b0);
    run_op("mul_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 3'b101, 1'b0);
    run_op("mul_zero",  1'b0, 8'h00, 8'h55, 16'h0000, 3'b010, 1'b0);
    run_op("div_200_7", 1'b1, 8'd200, 8'd7, {8'd4, 8'd28}, 3'b000, 1'b0);
    run_op("div_3_9",   1'b1, 8'd3, 8'd9, {8'd3, 8'd0}, 3'b010, 1'b0);
    run_op("div_5_0",   1'b1, 8'h05, 8'h00, 16'h05FF, 3'b101, 1'b0);
    run_op("div_255_1", 1'b1, 8'hFF, 8'h01, 16'h00FF, 3'b001, 1'b0);

    // Abort mid-RUN with start toggling; no done and all outputs cleared.
    op    = 1'b0;
    dataA = 8'hFF;
    dataB = 8'hFF;
    start = 1'b1;
    tick();
    for (int i = 1; i <= 3; i++) begin
      start = ~start;
      tick();
    end
    rst   = 1'b1;
    start = 1'b0;
    tick();
    rst = 1'b0;
    chk("abort_status", {14'd0, busy, done}, 16'd0);
    chk("abort_result", {outH, outL}, 16'h0000);
    chk("abort_flags", {13'd0, cout, zout, nout}, 16'd0);
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0) stray++;
    end
    chk("abort_no_activity", 16'(stray), 16'd0);

    run_op("mul_after_abort", 1'b0, 8'h0F, 8'h11, 16'h00FF, 3'b000, 1'b0);
    run_op("mul_scrambled", 1'b0, 8'h9C, 8'h23, 16'h1554, 3'b100, 1'b1);
    run_op("div_scrambled", 1'b1, 8'd200, 8'd7, {8'd4, 8'd28}, 3'b000, 1'b1);

    // start held high: one done every 10 cycles, first 9 cycles after acceptance.
    op    = 1'b0;
    dataA = 8'h03;
    dataB = 8'h05;
    start = 1'b1;
    tick();
    dones   = 0;
    first_t = -1;
    last_t  = -1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (done === 1'b1) begin
        dones++;
        if (first_t < 0) first_t = t;
        last_t = t;
      end
    end
    start = 1'b0;
    chk("held_done_count", 16'(dones), 16'd3);
    chk("held_first_done", 16'(first_t), 16'd9);
    chk("held_last_done", 16'(last_t), 16'd29);
    chk("held_result", {outH, outL}, 16'h000F);
    for (int i = 0; i < 12; i++) tick();
    chk("held_drained", {14'd0, busy, done}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 Parameters: none; datapath width fixed at 8 bits.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  1  0 = MUL (unsigned 8x8->16), 1 = DIV (unsigned 8/8).
REQ-006 dataA  input  8  multiplicand / dividend.
REQ-007 dataB  input  8  multiplier / divisor.
REQ-008 busy  output  1  high while an operation is iterating.
REQ-009 done  output  1  one-cycle pulse; results valid from this cycle on.
REQ-010 outH  output  8  product[15:8] / remainder.
REQ-011 outL  output  8  product[7:0] / quotient.
REQ-012 cout  output  1  MUL: product > 8'hFF; DIV: divisor was zero.
REQ-013 zout  output  1  MUL: 16-bit product == 0; DIV: quotient == 0.
REQ-014 nout  output  1  MUL: product[15]; DIV: quotient[7].

Function
REQ-015 FSM states: IDLE, RUN, DONE; IDLE->RUN on start=1, RUN->DONE after 8 RUN cycles, DONE->IDLE unconditionally.
REQ-016 On the IDLE edge accepting start, dataA, dataB and op shall be latched; input changes afterwards shall not affect the operation.
REQ-017 A 3-bit iteration counter shall clear on acceptance and increment each RUN cycle; RUN exits when it reaches 7.
REQ-018 MUL shall be shift-add, one multiplier bit per RUN cycle, LSB first, into a 16-bit accumulator.
REQ-019 DIV shall be restoring division, one quotient bit per RUN cycle, MSB first, with a 9-bit partial remainder.
REQ-020 Divisor zero shall not be special-cased in the datapath: result is quotient 8'hFF, remainder = dataA, cout=1, same latency.
REQ-021 Latency: start sampled at edge k -> busy=1 after edges k+1..k+8, done=1 for exactly one cycle after edge k+9, IDLE after edge k+10.
REQ-022 busy shall be 1 only in RUN; done shall be 1 only in DONE; never both.
REQ-023 outH, outL, cout, zout, nout shall be registered, updated only on entry to DONE, and held until the next DONE entry or reset.
REQ-024 start asserted in RUN or DONE shall be ignored (not queued); a start held high through DONE is accepted in the following IDLE cycle.
REQ-025 Back-to-back operations: minimum start-to-start spacing 10 cycles.

Reset
REQ-026 rst=1 at any edge shall force IDLE, counter 0, busy=0, done=0, outH=outL=8'h00, cout=zout=nout=0.
REQ-027 rst asserted mid-RUN shall abort the operation with no done pulse; first start after rst deasserts is accepted normally.
REQ-028 rst shall take priority over start on the same edge.

Structure
REQ-029 Op encodings (OP_MUL, OP_DIV) and FSM state encodings shall live in the shared CPU definitions package/header alongside the ALU mode codes.
REQ-030 Single module; no sub-module, since datapath and FSM share the accumulator and counter.
REQ-031 Flag semantics (cout/zout/nout) shall match the ALU's flag bus so the CPU flag register muxes them without translation.

Verification
REQ-032 MUL 8'h0F x 8'h11 -> outH=8'h00, outL=8'hFF, cout=0, zout=0, nout=0; done exactly 9 cycles after start edge.
REQ-033 MUL 8'hFF x 8'hFF -> outH=8'hFE, outL=8'h01, cout=1, nout=1, zout=0.
REQ-034 DIV 8'd200 / 8'd7 -> outL=8'd28, outH=8'd4, cout=0, zout=0; DIV 8'd3 / 8'd9 -> outL=0, outH=3, zout=1.
REQ-035 DIV 8'h05 / 8'h00 -> outL=8'hFF, outH=8'h05, cout=1, nout=1; same 9-cycle latency.
REQ-036 Start MUL, pulse rst on 4th RUN cycle, toggle start during RUN -> no done, all outputs 0 after rst edge; next start completes correctly.
REQ-037 Change dataA/dataB/op every cycle during RUN -> result reflects only latched operands; start held high continuously -> one done per 10 cycles.
